instr_fetch: RTL and testbench

Instruction fetch stage feeding the CPU's instruction register and decoder. Holds the program counter, issues single-word reads to instruction memory through a ready-handshake, and delivers each returned 16-bit instruction with a one-cycle `load` strobe that the instruction register samples. It also handles PC redirects, detects the HALT opcode, and flags memory timeouts.

---
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads one 16-bit word per request through a
// ready handshake, strobes `load` for the instruction register, detects HALT and timeouts.
`timescale 1ns/1ps

module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     instr_out,
  output logic            load,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0]  OP_HALT  = 3'b111;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_pc_q;
  logic            pend_q;
  logic [15:0]     instr_q;
  logic            load_q;
  logic            err_q;
  logic [7:0]      cnt_q;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values; `load_q` is defaulted low each cycle to make it a strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      pend_q    <= 1'b0;
      instr_q   <= 16'h0000;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pc_load) begin
            pc_q <= pc_in;
          end else if (fetch_req) begin
            state_q <= S_READ;
            cnt_q   <= 8'd0;
          end
        end
        S_READ: begin
          if (mem_ready) begin
            instr_q <= mem_rdata;
            load_q  <= 1'b1;
            pend_q  <= 1'b0;
            // A redirect arriving with the data beats any older pending target.
            if (pc_load)     pc_q <= pc_in;
            else if (pend_q) pc_q <= pend_pc_q;
            else             pc_q <= pc_q + PC_W'(1);
            state_q <= (mem_rdata[15:13] == OP_HALT) ? S_HALTED : S_IDLE;
          end else begin
            if (pc_load) begin
              pend_q    <= 1'b1;
              pend_pc_q <= pc_in;
            end
            if (cnt_q == CNT_LAST) begin
              err_q   <= 1'b1;
              state_q <= S_HALTED;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_HALTED: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd    = (state_q == S_READ);
  assign busy      = (state_q == S_READ);
  assign halted    = (state_q == S_HALTED);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign instr_out = instr_q;
  assign load      = load_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle vectors plus hand-written
// sequences for timeout and asynchronous reset in the middle of a read.
`timescale 1ns/1ps

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, pc_load, mem_ready;
  logic [7:0]  pc_in;
  logic [15:0] mem_rdata;
  logic        mem_rd, load, busy, halted, err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] instr_out;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .load(load), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fr, pl;
    logic [7:0]  pin;
    logic        rdy;
    logic [15:0] rdata;
    logic        rd;
    logic [7:0]  addr;
    logic        ld;
    logic [15:0] instr;
    logic [7:0]  pcv;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fr, input logic pl, input logic [7:0] pin,
                              input logic rdy, input logic [15:0] rdata, input logic rd,
                              input logic [7:0] addr, input logic ld, input logic [15:0] instr,
                              input logic [7:0] pcv, input logic hlt);
    vec_t v;
    v.fr = fr; v.pl = pl; v.pin = pin; v.rdy = rdy; v.rdata = rdata;
    v.rd = rd; v.addr = addr; v.ld = ld; v.instr = instr; v.pcv = pcv; v.hlt = hlt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; pc_load = 1'b0; pc_in = 8'h00; mem_ready = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " mem_rd"},    32'(mem_rd),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " pc"},        32'(pc),        32'h0);
    check({tag, " instr_out"}, 32'(instr_out), 32'h0);
    check({tag, " load"},      32'(load),      32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " halted"},    32'(halted),    32'h0);
    check({tag, " err"},       32'(err),       32'h0);
  endtask

  initial begin
    // Each row: inputs held for one cycle; expected outputs are the state seen in that cycle.
    //            fr    pl    pin    rdy   rdata      rd    addr   ld    instr      pc     hlt
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'hD105, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    // three wait states
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, 8'h01, 1'b0, 16'hD105, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 16'h1234, 8'h02, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b0, 16'h1234, 8'h02, 1'b0));
    // pc_load beats fetch_req in IDLE
    vecs.push_back(mk(1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b0, 16'h1234, 8'h02, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h40, 1'b0, 16'h1234, 8'h40, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h40, 1'b0, 16'h1234, 8'h40, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h0042, 1'b1, 8'h40, 1'b0, 16'h1234, 8'h40, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h41, 1'b1, 16'h0042, 8'h41, 1'b0));
    // redirect mid-READ at PC=5
    vecs.push_back(mk(1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 1'b0, 8'h41, 1'b0, 16'h0042, 8'h41, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b0, 16'h0042, 8'h05, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h20, 1'b0, 16'h0000, 1'b1, 8'h05, 1'b0, 16'h0042, 8'h05, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h1111, 1'b1, 8'h05, 1'b0, 16'h0042, 8'h05, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h20, 1'b1, 16'h1111, 8'h20, 1'b0));
    // redirect in the same cycle as mem_ready: newest pc_in wins
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h20, 1'b0, 16'h1111, 8'h20, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h30, 1'b0, 16'h0000, 1'b1, 8'h20, 1'b0, 16'h1111, 8'h20, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h31, 1'b1, 16'h2222, 1'b1, 8'h20, 1'b0, 16'h1111, 8'h20, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h31, 1'b1, 16'h2222, 8'h31, 1'b0));
    // PC wrap from FF
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h31, 1'b0, 16'h2222, 8'h31, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 16'h2222, 8'hFF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h3333, 1'b1, 8'hFF, 1'b0, 16'h2222, 8'hFF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h3333, 8'h00, 1'b0));
    // mem_ready in IDLE is ignored
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h3333, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h3333, 8'h00, 1'b0));
    // back-to-back fetches at zero wait: one word per two cycles
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 16'h0101, 1'b0, 8'h00, 1'b0, 16'h3333, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 16'h0101, 1'b1, 8'h00, 1'b0, 16'h3333, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 16'h0202, 1'b0, 8'h01, 1'b1, 16'h0101, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h0202, 1'b1, 8'h01, 1'b0, 16'h0101, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 16'h0202, 8'h02, 1'b0));
    // HALT opcode: delivered with load, then requests are ignored
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b0, 16'h0202, 8'h02, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'hE000, 1'b1, 8'h02, 1'b0, 16'h0202, 8'h02, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b1, 16'hE000, 8'h03, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 8'h03, 1'b0, 16'hE000, 8'h03, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b0, 16'hE000, 8'h03, 1'b1));

    reset = 1'b0;
    idle_inputs();
    do_reset();
    #1 check_reset_vals("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      fetch_req = vecs[i].fr;  pc_load   = vecs[i].pl;    pc_in = vecs[i].pin;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d mem_rd", i),    32'(mem_rd),    32'(vecs[i].rd));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].rd));
      check($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
      check($sformatf("v%0d load", i),      32'(load),      32'(vecs[i].ld));
      check($sformatf("v%0d instr_out", i), 32'(instr_out), 32'(vecs[i].instr));
      check($sformatf("v%0d pc", i),        32'(pc),        32'(vecs[i].pcv));
      check($sformatf("v%0d halted", i),    32'(halted),    32'(vecs[i].hlt));
      check($sformatf("v%0d err", i),       32'(err),       32'h0);
    end

    // Timeout: 16 READ cycles without mem_ready
    do_reset();
    #1 check_reset_vals("reset2");
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      check($sformatf("to c%0d mem_rd", c), 32'(mem_rd), 32'h1);
      check($sformatf("to c%0d err", c),    32'(err),    32'h0);
      check($sformatf("to c%0d load", c),   32'(load),   32'h0);
      @(negedge clk);
    end
    #1;
    check("to err",    32'(err),    32'h1);
    check("to halted", 32'(halted), 32'h1);
    check("to mem_rd", 32'(mem_rd), 32'h0);
    check("to load",   32'(load),   32'h0);
    check("to pc",     32'(pc),     32'h0);
    @(negedge clk);
    fetch_req = 1'b1;
    #1;
    check("to sticky err", 32'(err),    32'h1);
    check("to no read",    32'(mem_rd), 32'h0);

    // Asynchronous reset during READ, with mem_ready pending on the same cycle
    do_reset();
    #1 check_reset_vals("reset3");
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hE123;
    #1;
    check("mid mem_rd before", 32'(mem_rd), 32'h1);
    #1 reset = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    #1 check_reset_vals("async held");
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1 check_reset_vals("after release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
